// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package arb_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SERVE_IF = 2'd1,
      SERVE_MA = 2'd2
   } state_t;

   // Access size codes, shared by ma_read, ma_write and mem_size.
   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   // A data access is active when either the read or the write size is nonzero.
   function automatic logic ma_is_active(input logic [1:0] rd, input logic [1:0] wr);
      return (rd != SZ_NONE) || (wr != SZ_NONE);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MA requester ports and the memory-side port.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_stall;
   logic [1:0]        ma_read;
   logic [1:0]        ma_write;
   logic [ADDR_W-1:0] ma_addr;
   logic [DATA_W-1:0] ma_wdata;
   logic [DATA_W-1:0] ma_rdata;
   logic              ma_valid;
   logic              ma_stall;
   logic              mem_req;
   logic              mem_we;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, ma_read, ma_write, ma_addr, ma_wdata, mem_rdata, mem_ready,
      output if_rdata, if_valid, if_stall, ma_rdata, ma_valid, ma_stall,
             mem_req, mem_we, mem_size, mem_addr, mem_wdata
   );

   // Environment side: cpu stages and memory model.
   modport master (
      output if_req, if_addr, ma_read, ma_write, ma_addr, ma_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_valid, if_stall, ma_rdata, ma_valid, ma_stall,
             mem_req, mem_we, mem_size, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Saturating count of consecutive MA grants made while IF was waiting.
module arb_streak_ctr #(
   parameter int MAX_MA_STREAK = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);
   localparam int CW = $clog2(MAX_MA_STREAK + 1);

   logic [CW-1:0] count_r;

   // Clear wins over increment; increment stops at the saturation value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (inc && (count_r < CW'(MAX_MA_STREAK))) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign sat = (count_r >= CW'(MAX_MA_STREAK));
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch vs data access) for one memory port.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MAX_MA_STREAK = 4
) (
   input logic           clk,
   input logic           reset,
   mem_port_arbiter_if.slave bus
);
   state_t            state_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [1:0]        mem_size_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] ma_rdata_r;
   logic              if_valid_r;
   logic              ma_valid_r;

   logic              ma_active_s;
   logic              ma_is_write_s;
   logic [1:0]        ma_size_s;
   logic              if_cand_s;
   logic              ma_cand_s;
   logic              grant_if_s;
   logic              grant_ma_s;
   logic              sat_s;

   assign ma_active_s   = ma_is_active(bus.ma_read, bus.ma_write);
   assign ma_is_write_s = (bus.ma_write != SZ_NONE);
   assign ma_size_s     = ma_is_write_s ? bus.ma_write : bus.ma_read;

   // A requester seeing its own valid this cycle is still holding a finished request.
   assign if_cand_s = bus.if_req & ~if_valid_r;
   assign ma_cand_s = ma_active_s & ~ma_valid_r;

   // Arbitrate in IDLE: MA has priority unless IF has waited through a full streak.
   always_comb begin
      grant_if_s = 1'b0;
      grant_ma_s = 1'b0;
      if (state_r == IDLE) begin
         grant_ma_s = ma_cand_s & (~if_cand_s | ~sat_s);
         grant_if_s = if_cand_s & ~grant_ma_s;
      end else begin
         grant_if_s = 1'b0;
         grant_ma_s = 1'b0;
      end
   end

   arb_streak_ctr #(.MAX_MA_STREAK(MAX_MA_STREAK)) u_streak (
      .clk   (clk),
      .reset (reset),
      .inc   (grant_ma_s & bus.if_req),
      .clr   (grant_if_s),
      .sat   (sat_s)
   );

   // Main FSM: latch the winner's fields on grant, capture read data on mem_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_size_r  <= SZ_NONE;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         if_rdata_r  <= '0;
         ma_rdata_r  <= '0;
         if_valid_r  <= 1'b0;
         ma_valid_r  <= 1'b0;
      end else begin
         if_valid_r <= 1'b0;
         ma_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_if_s) begin
                  state_r     <= SERVE_IF;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b0;
                  mem_size_r  <= SZ_WORD;
                  mem_addr_r  <= bus.if_addr;
                  mem_wdata_r <= '0;
               end else if (grant_ma_s) begin
                  state_r     <= SERVE_MA;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= ma_is_write_s;
                  mem_size_r  <= ma_size_s;
                  mem_addr_r  <= bus.ma_addr;
                  mem_wdata_r <= bus.ma_wdata;
               end else begin
                  state_r <= IDLE;
               end
            end
            SERVE_IF: begin
               if (bus.mem_ready) begin
                  state_r     <= IDLE;
                  if_rdata_r  <= bus.mem_rdata;
                  if_valid_r  <= 1'b1;
                  mem_req_r   <= 1'b0;
                  mem_we_r    <= 1'b0;
                  mem_size_r  <= SZ_NONE;
                  mem_addr_r  <= '0;
                  mem_wdata_r <= '0;
               end else begin
                  state_r <= SERVE_IF;
               end
            end
            SERVE_MA: begin
               if (bus.mem_ready) begin
                  state_r <= IDLE;
                  if (!mem_we_r) begin
                     ma_rdata_r <= bus.mem_rdata;
                  end else begin
                     ma_rdata_r <= ma_rdata_r;
                  end
                  ma_valid_r  <= 1'b1;
                  mem_req_r   <= 1'b0;
                  mem_we_r    <= 1'b0;
                  mem_size_r  <= SZ_NONE;
                  mem_addr_r  <= '0;
                  mem_wdata_r <= '0;
               end else begin
                  state_r <= SERVE_MA;
               end
            end
            default: begin
               state_r   <= IDLE;
               mem_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_size  = mem_size_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.ma_rdata  = ma_rdata_r;
   assign bus.if_valid  = if_valid_r;
   assign bus.ma_valid  = ma_valid_r;

   // Stalls are combinational but forced low while reset is asserted.
   assign bus.if_stall = reset & bus.if_req & ~if_valid_r;
   assign bus.ma_stall = reset & ma_active_s & ~ma_valid_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_MA_STREAK(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One round where IF and MA request together; exp_ma selects the expected winner.
   task automatic collide_round(input bit exp_ma, input logic [31:0] idx);
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h0000_0300;
      bus.ma_write = 2'b11;
      bus.ma_addr  = 32'h0000_0200 + idx;
      bus.ma_wdata = idx;
      step();
      check($sformatf("starve_we_%0d", idx), {31'd0, bus.mem_we}, {31'd0, exp_ma});
      check($sformatf("starve_addr_%0d", idx), bus.mem_addr,
            exp_ma ? (32'h0000_0200 + idx) : 32'h0000_0300);
      step();
      if (exp_ma) begin
         check($sformatf("starve_mavalid_%0d", idx), {31'd0, bus.ma_valid}, 32'd1);
      end else begin
         check($sformatf("starve_ifvalid_%0d", idx), {31'd0, bus.if_valid}, 32'd1);
      end
      bus.if_req   = 1'b0;
      bus.ma_write = 2'b00;
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h0;
      bus.ma_read   = 2'b11;
      bus.ma_write  = 2'b00;
      bus.ma_addr   = 32'h0;
      bus.ma_wdata  = 32'h0;
      bus.mem_rdata = 32'h0;
      bus.mem_ready = 1'b0;
      step();
      step();
      // Reset state, with requests present to show stalls are held low.
      check("rst_mem_req",  {31'd0, bus.mem_req},  32'd0);
      check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rst_ma_valid", {31'd0, bus.ma_valid}, 32'd0);
      check("rst_if_stall", {31'd0, bus.if_stall}, 32'd0);
      check("rst_ma_stall", {31'd0, bus.ma_stall}, 32'd0);
      check("rst_if_rdata", bus.if_rdata, 32'd0);
      check("rst_ma_rdata", bus.ma_rdata, 32'd0);
      bus.if_req  = 1'b0;
      bus.ma_read = 2'b00;
      step();
      reset = 1'b1;
      step();

      // IF only, memory ready in the first serve cycle.
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0050_0093;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h0000_0010;
      #1;
      check("if1_stall_c0", {31'd0, bus.if_stall}, 32'd1);
      check("if1_req_c0",   {31'd0, bus.mem_req},  32'd0);
      step();
      check("if1_req_c1",   {31'd0, bus.mem_req},  32'd1);
      check("if1_addr_c1",  bus.mem_addr, 32'h0000_0010);
      check("if1_we_c1",    {31'd0, bus.mem_we}, 32'd0);
      check("if1_size_c1",  {30'd0, bus.mem_size}, 32'd3);
      check("if1_valid_c1", {31'd0, bus.if_valid}, 32'd0);
      step();
      check("if1_valid_c2", {31'd0, bus.if_valid}, 32'd1);
      check("if1_rdata_c2", bus.if_rdata, 32'h0050_0093);
      check("if1_req_c2",   {31'd0, bus.mem_req}, 32'd0);
      check("if1_stall_c2", {31'd0, bus.if_stall}, 32'd0);
      bus.if_req = 1'b0;
      step();
      check("if1_valid_c3", {31'd0, bus.if_valid}, 32'd0);
      check("if1_rdata_hold", bus.if_rdata, 32'h0050_0093);

      // Collision: MA first, IF granted in the ma_valid cycle.
      bus.mem_rdata = 32'hDEAD_0001;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h0000_0014;
      bus.ma_read   = 2'b11;
      bus.ma_addr   = 32'h0000_0100;
      step();
      check("col_addr_ma", bus.mem_addr, 32'h0000_0100);
      check("col_we_ma",   {31'd0, bus.mem_we}, 32'd0);
      step();
      check("col_ma_valid", {31'd0, bus.ma_valid}, 32'd1);
      check("col_ma_rdata", bus.ma_rdata, 32'hDEAD_0001);
      check("col_if_stall", {31'd0, bus.if_stall}, 32'd1);
      bus.ma_read   = 2'b00;
      bus.mem_rdata = 32'h1111_2222;
      step();
      check("col_req_if",  {31'd0, bus.mem_req}, 32'd1);
      check("col_addr_if", bus.mem_addr, 32'h0000_0014);
      check("col_ma_valid_off", {31'd0, bus.ma_valid}, 32'd0);
      step();
      check("col_if_valid", {31'd0, bus.if_valid}, 32'd1);
      check("col_if_rdata", bus.if_rdata, 32'h1111_2222);
      bus.if_req = 1'b0;
      step();

      // Byte store: ma_rdata must not change.
      bus.mem_rdata = 32'h5555_5555;
      bus.ma_write  = 2'b01;
      bus.ma_addr   = 32'h0000_0023;
      bus.ma_wdata  = 32'h0000_00AB;
      step();
      check("st_we",    {31'd0, bus.mem_we}, 32'd1);
      check("st_size",  {30'd0, bus.mem_size}, 32'd1);
      check("st_wdata", bus.mem_wdata, 32'h0000_00AB);
      check("st_addr",  bus.mem_addr, 32'h0000_0023);
      check("st_stall", {31'd0, bus.ma_stall}, 32'd1);
      step();
      check("st_valid",  {31'd0, bus.ma_valid}, 32'd1);
      check("st_rdata",  bus.ma_rdata, 32'hDEAD_0001);
      check("st_stall_off", {31'd0, bus.ma_stall}, 32'd0);
      bus.ma_write = 2'b00;
      step();
      check("st_valid_off", {31'd0, bus.ma_valid}, 32'd0);

      // Three wait states: valid five cycles after the request.
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hCAFE_F00D;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h0000_0080;
      for (int c = 1; c <= 4; c++) begin
         step();
         check($sformatf("ws_addr_c%0d", c), bus.mem_addr, 32'h0000_0080);
         check($sformatf("ws_req_c%0d", c), {31'd0, bus.mem_req}, 32'd1);
         check($sformatf("ws_valid_c%0d", c), {31'd0, bus.if_valid}, 32'd0);
      end
      bus.mem_ready = 1'b1;
      step();
      check("ws_valid_c5", {31'd0, bus.if_valid}, 32'd1);
      check("ws_rdata_c5", bus.if_rdata, 32'hCAFE_F00D);
      bus.if_req = 1'b0;
      step();

      // Starvation guard: four MA wins, then IF; the IF grant clears the streak.
      for (int r = 0; r < 4; r++) collide_round(1'b1, r);
      collide_round(1'b0, 32'd4);
      for (int r = 5; r < 9; r++) collide_round(1'b1, r);
      collide_round(1'b0, 32'd9);

      // Reset asserted mid SERVE_MA.
      bus.mem_ready = 1'b0;
      bus.ma_read   = 2'b11;
      bus.ma_addr   = 32'h0000_0044;
      step();
      check("mr_req_before", {31'd0, bus.mem_req}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("mr_req_async",  {31'd0, bus.mem_req}, 32'd0);
      check("mr_addr_async", bus.mem_addr, 32'd0);
      check("mr_ma_stall",   {31'd0, bus.ma_stall}, 32'd0);
      check("mr_if_rdata",   bus.if_rdata, 32'd0);
      check("mr_ma_rdata",   bus.ma_rdata, 32'd0);
      step();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0050;
      reset       = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h7777_8888;
      step();
      check("mr_post_addr", bus.mem_addr, 32'h0000_0044);
      check("mr_post_req",  {31'd0, bus.mem_req}, 32'd1);
      step();
      check("mr_post_valid", {31'd0, bus.ma_valid}, 32'd1);
      check("mr_post_rdata", bus.ma_rdata, 32'h7777_8888);
      bus.ma_read = 2'b00;
      step();
      check("mr_post_if_addr", bus.mem_addr, 32'h0000_0050);
      step();
      check("mr_post_if_valid", {31'd0, bus.if_valid}, 32'd1);
      bus.if_req = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the IF-stage instruction fetch and the MA-stage data access.
- Sits between the cpu and the memory model in the top-level and bench.
- Serialises requests, holds the losing stage with a stall, and returns read data with a one-cycle valid pulse.
- Includes a starvation guard so back-to-back loads and stores cannot lock out fetch indefinitely.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_MA_STREAK, 4, maximum consecutive MA grants while IF is waiting; after this, IF wins the next arbitration.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, registered.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_stall  out  1  IF stage must hold.
- ma_read  in  2  00 none, 01 byte, 10 half, 11 word.
- ma_write  in  2  same encoding as ma_read.
- ma_addr  in  ADDR_W  data address.
- ma_wdata  in  DATA_W  store data.
- ma_rdata  out  DATA_W  load data, registered.
- ma_valid  out  1  one-cycle completion pulse, for both loads and stores.
- ma_stall  out  1  MA stage must hold.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  1 = write.
- mem_size  out  2  size code, same encoding as ma_read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the current transaction this cycle.

Behaviour:
- Reset (reset=0, async): state IDLE, streak counter 0; every output 0, including mem_req, if_valid, ma_valid, both rdata registers and both stalls.
- Reset asserted mid-transaction abandons that transaction. After reset, the requester must re-issue.
- ma_active = (ma_read != 0) | (ma_write != 0).
- If ma_read and ma_write are both nonzero, the access is treated as a write of size ma_write.
- States:
  - IDLE: arbitrate. A requester whose valid is high this cycle is masked, because its request is stale.
  - SERVE_IF: mem_req=1, mem_we=0, mem_size=11. Latched if_addr drives mem_addr.
  - SERVE_MA: mem_req=1. mem_we, mem_size, mem_addr and mem_wdata are driven from values latched at grant.
- Arbitration, applied in IDLE:
  - Only one requester: it wins.
  - Both requesting: MA wins, unless streak >= MAX_MA_STREAK, in which case IF wins.
  - On grant: latch request fields, go to SERVE_x.
- Streak counter:
  - Increments, saturating at MAX_MA_STREAK, on each MA grant made while if_req=1.
  - Clears on any IF grant.
  - Holds otherwise.
- mem_req and mem_* outputs are registered and stay stable for the whole SERVE state; they change only on grant or on completion.
- Completion: in SERVE_x with mem_ready=1:
  - SERVE_IF: capture mem_rdata into if_rdata.
  - SERVE_MA read: capture mem_rdata into ma_rdata. For writes, ma_rdata is unchanged.
  - Next cycle: the matching valid is 1, state is IDLE, mem_req is 0.
- mem_ready is ignored in IDLE.
- Latency: request to valid is 2 + W cycles, where W = cycles of mem_ready low in SERVE. Minimum is 2.
- Each valid is high for exactly one cycle; the rdata registers hold their value until the next capture.
- Stalls (combinational): if_stall = if_req & ~if_valid; ma_stall = ma_active & ~ma_valid.
- Simultaneous events:
  - A request arriving in the valid cycle of the other requester is granted that same IDLE cycle.
  - IF and MA arriving in the same cycle: priority rule above applies.
- Request withdrawn while its transaction is in SERVE: the transaction still completes and valid still pulses.

Decomposition:
- Shared package arb_pkg holds: state enum (IDLE, SERVE_IF, SERVE_MA); size constants SZ_NONE=00, SZ_BYTE=01, SZ_HALF=10, SZ_WORD=11.
- One natural sub-module: arb_streak_ctr, a saturating counter with inc, clr and sat output, parameterised by MAX_MA_STREAK.

Test Plan:
- Reset then IF only: if_req=1, if_addr=0x10, memory ready after 1 cycle with 0x00500093 -> mem_req high 1 cycle; if_valid pulses at cycle 2; if_rdata=0x00500093; if_stall 1 then 0.
- Collision: if_req and ma_read=11 (addr 0x100) in the same cycle, streak=0 -> MA served first, ma_valid; IF granted in the ma_valid cycle; if_valid 2 cycles later.
- Starvation: if_req held, 5 back-to-back MA word writes -> exactly 4 MA grants; 5th grant goes to IF; streak returns to 0.
- Store: ma_write=01, ma_addr=0x23, ma_wdata=0xAB -> mem_we=1, mem_size=01, mem_wdata=0xAB; ma_valid pulses; ma_rdata unchanged.
- Wait states: mem_ready low 3 cycles -> mem_addr stable throughout; valid at cycle 5 after request.
- Reset mid-SERVE_MA: reset=0 asynchronously -> mem_req=0 immediately; all outputs 0; after release, first grant follows the priority rule and is served normally.
